pipeline_hazard_ctrl: RTL and testbench

- Central freeze/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Combines three hazard sources into per-register freeze/flush controls:
  - data hazards detected in ID against EX/MEM destinations;
  - taken branches resolved in EX;
  - multi-cycle SRAM accesses in MEM.
- Drives the IF/ID register's freeze and flush inputs, the PC enable, and the bubble/hold inputs of the later stage registers.
- Keeps saturating stall and flush statistics counters.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/mem_stall_fsm.sv | 65 ++++++
 rtl/pipeline_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    localparam int DEF_REG_W   = 4;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_WD_W    = 7;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/mem_stall_fsm.sv
// rtl/mem_stall_fsm.sv - SRAM access stall sequencer with watchdog and sticky error
module mem_stall_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int WD_W    = DEF_WD_W
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic sram_ready,
    output logic mem_stall,
    output logic mem_err
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    mem_state_e      state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
        end
    end

    // sram_ready is only honoured in WAIT, so every access stalls at least once
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        err_d     = err_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    mem_stall = 1'b1;
                    state_d   = WAIT;
                    wd_d      = '0;
                end
            end
            WAIT: begin
                if (sram_ready) begin
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    mem_stall = 1'b1;
                    wd_d      = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_err = err_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - freeze/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = DEF_REG_W,
    parameter int FORWARD = 1,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int WD_W    = DEF_WD_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_uses_src1,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_mem_read,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             sram_ready,
    input  logic             stat_clr,
    output logic             pc_freeze,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_freeze,
    output logic             ex_mem_freeze,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic mem_stall;
    logic src1_hit, src2_hit, raw;
    logic [6:0] ctl;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

    mem_stall_fsm #(
        .TIMEOUT (TIMEOUT),
        .WD_W    (WD_W)
    ) u_mem_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .sram_ready (sram_ready),
        .mem_stall  (mem_stall),
        .mem_err    (mem_err)
    );

    // With forwarding only a load in EX cannot be bypassed in time
    always_comb begin
        if (FORWARD != 0) begin
            src1_hit = exe_wb_en & exe_mem_read & (exe_dest == id_src1);
            src2_hit = exe_wb_en & exe_mem_read & (exe_dest == id_src2);
        end else begin
            src1_hit = (exe_wb_en & (exe_dest == id_src1)) | (mem_wb_en & (mem_dest == id_src1));
            src2_hit = (exe_wb_en & (exe_dest == id_src2)) | (mem_wb_en & (mem_dest == id_src2));
        end
        raw = (id_uses_src1 & src1_hit) | (id_two_src & src2_hit);
    end

    // ctl = {pc_frz, if_id_frz, if_id_fl, id_ex_fl, id_ex_frz, ex_mem_frz, mem_wb_fl}
    always_comb begin
        ctl = 7'b0;
        if (mem_stall)         ctl = 7'b1100111;
        else if (branch_taken) ctl = 7'b0011000;
        else if (raw)          ctl = 7'b1101000;
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stat_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (ctl[6] && stall_q != '1)                    stall_d = stall_q + 1'b1;
            if (!mem_stall && branch_taken && flush_q != '1) flush_d = flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign {pc_freeze, if_id_freeze, if_id_flush, id_ex_flush,
            id_ex_freeze, ex_mem_freeze, mem_wb_flush} = rst ? ctl : 7'b0;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - randomized scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] id_src1 = '0, id_src2 = '0, exe_dest = '0, mem_dest = '0;
    logic       id_two_src = 0, id_uses_src1 = 0, exe_wb_en = 0, exe_mem_read = 0;
    logic       mem_wb_en = 0, branch_taken = 0, mem_req = 0, sram_ready = 0, stat_clr = 0;

    wire [6:0]  ctl_a, ctl_b;
    wire        err_a, err_b;
    wire [3:0]  scnt_a, fcnt_a;
    wire [15:0] scnt_b, fcnt_b;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(4), .FORWARD(1), .TIMEOUT(4), .WD_W(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_src1(id_uses_src1), .exe_wb_en(exe_wb_en),
        .exe_dest(exe_dest), .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .branch_taken(branch_taken), .mem_req(mem_req),
        .sram_ready(sram_ready), .stat_clr(stat_clr),
        .pc_freeze(ctl_a[6]), .if_id_freeze(ctl_a[5]), .if_id_flush(ctl_a[4]),
        .id_ex_flush(ctl_a[3]), .id_ex_freeze(ctl_a[2]), .ex_mem_freeze(ctl_a[1]),
        .mem_wb_flush(ctl_a[0]), .mem_err(err_a), .stall_cycles(scnt_a), .flush_count(fcnt_a)
    );

    pipeline_hazard_ctrl #(.REG_W(4), .FORWARD(0), .TIMEOUT(64), .WD_W(7), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_src1(id_uses_src1), .exe_wb_en(exe_wb_en),
        .exe_dest(exe_dest), .exe_mem_read(exe_mem_read), .mem_wb_en(mem_wb_en),
        .mem_dest(mem_dest), .branch_taken(branch_taken), .mem_req(mem_req),
        .sram_ready(sram_ready), .stat_clr(stat_clr),
        .pc_freeze(ctl_b[6]), .if_id_freeze(ctl_b[5]), .if_id_flush(ctl_b[4]),
        .id_ex_flush(ctl_b[3]), .id_ex_freeze(ctl_b[2]), .ex_mem_freeze(ctl_b[1]),
        .mem_wb_flush(ctl_b[0]), .mem_err(err_b), .stall_cycles(scnt_b), .flush_count(fcnt_b)
    );

    typedef struct packed {
        logic [1:0][6:0]  ctl;
        logic [1:0]       err;
        logic [1:0][15:0] scnt;
        logic [1:0][15:0] fcnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state, one slot per DUT configuration
    bit m_busy[2];
    int m_wait[2];
    bit m_err[2];
    int m_scnt[2];
    int m_fcnt[2];

    function automatic bool_hit(int d, logic [3:0] src);
        if (d == 0) return exe_wb_en && exe_mem_read && (exe_dest == src);
        return (exe_wb_en && exe_dest == src) || (mem_wb_en && mem_dest == src);
    endfunction

    task automatic model_cycle();
        exp_t e;
        int   tmo, maxv;
        bit   stall, raw;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            tmo  = (d == 0) ? 4 : 64;
            maxv = (d == 0) ? 15 : 65535;
            if (!rst) begin
                m_busy[d] = 0; m_wait[d] = 0; m_err[d] = 0; m_scnt[d] = 0; m_fcnt[d] = 0;
                continue;
            end
            e.err[d]  = m_err[d];
            e.scnt[d] = 16'(m_scnt[d]);
            e.fcnt[d] = 16'(m_fcnt[d]);
            if (!m_busy[d]) begin
                stall = mem_req;
                if (mem_req) begin m_busy[d] = 1; m_wait[d] = 0; end
            end else if (sram_ready) begin
                stall = 0; m_busy[d] = 0;
            end else if (m_wait[d] == tmo - 1) begin
                stall = 0; m_busy[d] = 0; m_err[d] = 1;
            end else begin
                stall = 1; m_wait[d]++;
            end
            raw = (id_uses_src1 && bool_hit(d, id_src1)) || (id_two_src && bool_hit(d, id_src2));
            if (stall)             e.ctl[d] = 7'b1100111;
            else if (branch_taken) e.ctl[d] = 7'b0011000;
            else if (raw)          e.ctl[d] = 7'b1101000;
            if (stat_clr) begin
                m_scnt[d] = 0; m_fcnt[d] = 0;
            end else begin
                if (e.ctl[d][6] && m_scnt[d] < maxv) m_scnt[d]++;
                if (!stall && branch_taken && m_fcnt[d] < maxv) m_fcnt[d]++;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic chk(string name, int d, logic [15:0] act, logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("ctl",      0, {9'b0, ctl_a}, {9'b0, e.ctl[0]});
            chk("ctl",      1, {9'b0, ctl_b}, {9'b0, e.ctl[1]});
            chk("mem_err",  0, {15'b0, err_a}, {15'b0, e.err[0]});
            chk("mem_err",  1, {15'b0, err_b}, {15'b0, e.err[1]});
            chk("stall_ct", 0, {12'b0, scnt_a}, e.scnt[0]);
            chk("stall_ct", 1, scnt_b, e.scnt[1]);
            chk("flush_ct", 0, {12'b0, fcnt_a}, e.fcnt[0]);
            chk("flush_ct", 1, fcnt_b, e.fcnt[1]);
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            model_cycle();
        end
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            rst          = !((i % 300) >= 298);
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            exe_dest     = 4'($urandom_range(0, 3));
            mem_dest     = 4'($urandom_range(0, 3));
            id_uses_src1 = ($urandom_range(0, 3) != 0);
            id_two_src   = ($urandom_range(0, 1) != 0);
            exe_wb_en    = ($urandom_range(0, 3) != 0);
            exe_mem_read = ($urandom_range(0, 1) != 0);
            mem_wb_en    = ($urandom_range(0, 1) != 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            mem_req      = ($urandom_range(0, 3) == 0);
            sram_ready   = ($urandom_range(0, 2) == 0);
            stat_clr     = ($urandom_range(0, 39) == 0);
            if ((i % 300) == 297 || (i >= 600 && i < 760)) begin
                mem_req    = 1'b1;
                sram_ready = 1'b0;
            end
            model_cycle();
        end
        @(posedge clk); #1;
        @(negedge clk); #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
